// File: rtl/pokey_pkg.sv
// ============================================================================
// Module   : pokey_pkg
// Brief    : Shared types and default constants for the POKEY timer enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pokey_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    localparam int c_DIV64_DEFAULT     = 28;
    localparam int c_DIV15_DEFAULT     = 114;
    localparam int c_FLUSH_LEN_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/pokey_prescaler.sv
// ============================================================================
// Module   : pokey_prescaler
// Brief    : 7-bit tick prescaler with wrap compare and a registered strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pokey_prescaler #(
    parameter int DIV = 28
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic clear,
    input  logic tick,
    output logic wrap,
    output logic strobe
);

    localparam logic [6:0] c_LAST = 7'(DIV - 1);

    logic [6:0] r_cnt;
    logic       r_strobe;

    assign wrap   = tick && !clear && (r_cnt == c_LAST);
    assign strobe = r_strobe;

    always_ff @(posedge clk) begin
        if (sync_reset || clear) begin
            r_cnt    <= 7'd0;
            r_strobe <= 1'b0;
        end else begin
            if (tick) begin
                r_cnt <= wrap ? 7'd0 : r_cnt + 7'd1;
            end
            r_strobe <= wrap;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pokey_enable_sched.sv
// ============================================================================
// Module   : pokey_enable_sched
// Brief    : Channel enable scheduler: flush/restart FSM plus 64k/15k bases.
//            Optional flush_done pulse when POKEY_SCHED_DONE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pokey_enable_sched
    import pokey_pkg::*;
#(
    parameter int DIV64     = c_DIV64_DEFAULT,
    parameter int DIV15     = c_DIV15_DEFAULT,
    parameter int FLUSH_LEN = c_FLUSH_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       clk_en_in,
    input  logic       base_15k,
    input  logic [3:0] ch_fast,
    input  logic       stimer_wr,
    output logic [3:0] ch_enable,
    output logic       base_strobe,
    output logic       dl_sync_reset,
    output logic       busy
`ifdef POKEY_SCHED_DONE_EN
    ,
    output logic       flush_done
`endif
);

    localparam logic [3:0] c_FLUSH_LAST = 4'(FLUSH_LEN - 1);

    sched_state_e r_state, w_state_nxt;
    logic [3:0]   r_fcnt, w_fcnt_nxt;
    logic         r_sel;
    logic         r_sel_q;
    logic [3:0]   r_ch_en;
    logic         w_clear;
    logic         w_wrap64, w_wrap15;
    logic         w_stb64, w_stb15;
    logic         w_base_nxt;

    // Prescalers only count in RUN and are zeroed in the cycle a restart is seen.
    assign w_clear    = (r_state != ST_RUN) || stimer_wr;
    assign w_base_nxt = r_sel ? w_wrap15 : w_wrap64;

    pokey_prescaler #(.DIV(DIV64)) u_pre64 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (w_clear),
        .tick       (clk_en_in),
        .wrap       (w_wrap64),
        .strobe     (w_stb64)
    );

    pokey_prescaler #(.DIV(DIV15)) u_pre15 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (w_clear),
        .tick       (clk_en_in),
        .wrap       (w_wrap15),
        .strobe     (w_stb15)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = 4'd0;
            end
            ST_FLUSH: begin
                if (stimer_wr) begin
                    w_fcnt_nxt = 4'd0;
                end else if (r_fcnt == c_FLUSH_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (stimer_wr) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = 4'd0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state <= ST_IDLE;
            r_fcnt  <= 4'd0;
            r_sel   <= 1'b0;
            r_sel_q <= 1'b0;
            r_ch_en <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            // Base selection only switches on the selected prescaler's wrap while running.
            if (w_clear || w_base_nxt) begin
                r_sel <= base_15k;
            end
            r_sel_q <= r_sel;
            r_ch_en <= (ch_fast & {4{clk_en_in && !w_clear}}) |
                       (~ch_fast & {4{w_base_nxt}});
        end
    end

    assign base_strobe   = r_sel_q ? w_stb15 : w_stb64;
    assign ch_enable     = r_ch_en;
    assign dl_sync_reset = (r_state == ST_FLUSH);
    assign busy          = (r_state != ST_RUN);

`ifdef POKEY_SCHED_DONE_EN
    logic r_done;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FLUSH) && (w_state_nxt == ST_RUN);
        end
    end

    assign flush_done = r_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pokey_enable_sched.sv
// ============================================================================
// Module   : tb_pokey_enable_sched
// Brief    : Self-checking bench for pokey_enable_sched (vectors, sequences, random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pokey_enable_sched;

    localparam int DIV64     = 28;
    localparam int DIV15     = 114;
    localparam int FLUSH_LEN = 4;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       clk_en_in = 1'b0;
    logic       base_15k = 1'b0;
    logic [3:0] ch_fast = 4'd0;
    logic       stimer_wr = 1'b0;
    logic [3:0] ch_enable;
    logic       base_strobe;
    logic       dl_sync_reset;
    logic       busy;
`ifdef POKEY_SCHED_DONE_EN
    logic       flush_done;
`endif

    pokey_enable_sched #(
        .DIV64     (DIV64),
        .DIV15     (DIV15),
        .FLUSH_LEN (FLUSH_LEN)
    ) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .clk_en_in     (clk_en_in),
        .base_15k      (base_15k),
        .ch_fast       (ch_fast),
        .stimer_wr     (stimer_wr),
        .ch_enable     (ch_enable),
        .base_strobe   (base_strobe),
        .dl_sync_reset (dl_sync_reset),
        .busy          (busy)
`ifdef POKEY_SCHED_DONE_EN
        ,
        .flush_done    (flush_done)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=flush 2=run; ticks counted since RUN entry.
    int         m_mode = 0;
    int         m_left = 0;
    int         m_t64 = 0;
    int         m_t15 = 0;
    int         m_sel = 0;
    logic [3:0] e_ch = 4'd0;
    logic       e_base = 1'b0;
    logic       e_done = 1'b0;

    task automatic model_step();
        bit hit;
        e_ch   = 4'd0;
        e_base = 1'b0;
        e_done = 1'b0;
        if (sync_reset) begin
            m_mode = 0;
            m_sel  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_left = FLUSH_LEN;
            m_sel  = int'(base_15k);
        end else if (m_mode == 1) begin
            m_sel = int'(base_15k);
            if (stimer_wr) begin
                m_left = FLUSH_LEN;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_t64  = 0;
                    m_t15  = 0;
                    e_done = 1'b1;
                end
            end
        end else begin
            if (stimer_wr) begin
                m_mode = 1;
                m_left = FLUSH_LEN;
            end else if (clk_en_in) begin
                m_t64++;
                m_t15++;
                hit = (m_sel != 0) ? (m_t15 % DIV15 == 0) : (m_t64 % DIV64 == 0);
                e_base = hit;
                for (int i = 0; i < 4; i++) e_ch[i] = ch_fast[i] ? 1'b1 : hit;
                if (hit) m_sel = int'(base_15k);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("ch_enable", 32'(ch_enable), 32'(e_ch));
        check("base_strobe", 32'(base_strobe), 32'(e_base));
        check("dl_sync_reset", 32'(dl_sync_reset), 32'(m_mode == 1));
        check("busy", 32'(busy), 32'(m_mode != 2));
`ifdef POKEY_SCHED_DONE_EN
        check("flush_done", 32'(flush_done), 32'(e_done));
`endif
    endtask

    task automatic go_run();
        sync_reset = 1'b1;
        clk_en_in  = 1'b0;
        stimer_wr  = 1'b0;
        cyc();
        sync_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!busy) break;
        end
        check("reach_run", 32'(busy), 32'd0);
    endtask

    task automatic ticks_to_strobe(output int n);
        n = 0;
        clk_en_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc();
            n++;
            if (base_strobe) break;
        end
    endtask

    task automatic count_flush(output int n);
        n = 32'(dl_sync_reset);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!busy) break;
            n += 32'(dl_sync_reset);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       tk;
        logic       b15;
        logic [3:0] fast;
        logic       st;
        logic [3:0] x_ch;
        logic       x_base;
        logic       x_dl;
        logic       x_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int n;
        int c0, c1, c2, c3;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};

        #1;
        foreach (vecs[k]) begin
            sync_reset = vecs[k].rst;
            clk_en_in  = vecs[k].tk;
            base_15k   = vecs[k].b15;
            ch_fast    = vecs[k].fast;
            stimer_wr  = vecs[k].st;
            cyc();
            check("vec_ch", 32'(ch_enable), 32'(vecs[k].x_ch));
            check("vec_base", 32'(base_strobe), 32'(vecs[k].x_base));
            check("vec_dl", 32'(dl_sync_reset), 32'(vecs[k].x_dl));
            check("vec_busy", 32'(busy), 32'(vecs[k].x_busy));
        end

        // 64 kHz base on all channels: strobe every DIV64 ticks from RUN entry.
        base_15k = 1'b0;
        ch_fast  = 4'h0;
        go_run();
        ticks_to_strobe(n);
        check("first_strobe_ticks", 32'(n), 32'(DIV64));
        check("all_ch_on_strobe", 32'(ch_enable), 32'hF);
        ticks_to_strobe(n);
        check("second_strobe_ticks", 32'(n), 32'(DIV64));

        // Mixed fast/15 kHz channels.
        base_15k = 1'b1;
        ch_fast  = 4'b0101;
        go_run();
        clk_en_in = 1'b1;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < 2 * DIV15; i++) begin
            cyc();
            c0 += 32'(ch_enable[0]);
            c1 += 32'(ch_enable[1]);
            c2 += 32'(ch_enable[2]);
            c3 += 32'(ch_enable[3]);
        end
        check("fast_ch0_pulses", 32'(c0), 32'(2 * DIV15));
        check("slow_ch1_pulses", 32'(c1), 32'd2);
        check("fast_ch2_pulses", 32'(c2), 32'(2 * DIV15));
        check("slow_ch3_pulses", 32'(c3), 32'd2);

        // Restart mid-count.
        base_15k = 1'b0;
        ch_fast  = 4'h0;
        go_run();
        clk_en_in = 1'b1;
        repeat (17) cyc();
        stimer_wr = 1'b1;
        cyc();
        stimer_wr = 1'b0;
        check("restart_ch_zero", 32'(ch_enable), 32'd0);
        check("restart_dl_high", 32'(dl_sync_reset), 32'd1);
        count_flush(n);
        check("restart_flush_len", 32'(n), 32'(FLUSH_LEN));
        ticks_to_strobe(n);
        check("restart_strobe_ticks", 32'(n), 32'(DIV64));

        // Restart on flush cycle 3, then reset together with restart.
        clk_en_in  = 1'b0;
        sync_reset = 1'b1;
        cyc();
        sync_reset = 1'b0;
        cyc();
        cyc();
        cyc();
        stimer_wr = 1'b1;
        cyc();
        stimer_wr = 1'b0;
        count_flush(n);
        check("extended_flush_len", 32'(n), 32'(FLUSH_LEN));
        sync_reset = 1'b1;
        stimer_wr  = 1'b1;
        clk_en_in  = 1'b1;
        cyc();
        check("rst_stimer_dl", 32'(dl_sync_reset), 32'd0);
        check("rst_stimer_busy", 32'(busy), 32'd1);
        stimer_wr = 1'b0;
        sync_reset = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 20000; i++) begin
            sync_reset = ($urandom_range(0, 999) == 0);
            clk_en_in  = ($urandom_range(0, 1) == 0);
            stimer_wr  = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 299) == 0) base_15k = ~base_15k;
            if ($urandom_range(0, 199) == 0) ch_fast = 4'($urandom);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pokey_enable_sched.md
POKEY_ENABLE_SCHED -- requirements
Module: pokey_enable_sched

Interface
REQ-001 SHALL have parameter DIV64, default 28, meaning 64 kHz base divide ratio in clk_en_in ticks (range 2..127).
REQ-002 SHALL have parameter DIV15, default 114, meaning 15 kHz base divide ratio in clk_en_in ticks (range 2..127).
REQ-003 SHALL have parameter FLUSH_LEN, default 4, meaning number of clk cycles dl_sync_reset is held during a flush (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port sync_reset, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port clk_en_in, input, 1, the 1.79 MHz master tick, one clk wide.
REQ-007 SHALL have port base_15k, input, 1, base select: 1 = 15 kHz, 0 = 64 kHz.
REQ-008 SHALL have port ch_fast, input, 4, per channel: 1 = clock the channel from clk_en_in, 0 = clock it from the selected base.
REQ-009 SHALL have port stimer_wr, input, 1, one-cycle restart request (STIMER write).
REQ-010 SHALL have port ch_enable, output, 4, per-channel enable strobes for the timer delay lines.
REQ-011 SHALL have port base_strobe, output, 1, the selected base tick (64 kHz or 15 kHz).
REQ-012 SHALL have port dl_sync_reset, output, 1, drives the sync_reset input of every channel delay line.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not RUN.

Function
REQ-014 SHALL implement FSM states IDLE, FLUSH and RUN.
REQ-015 SHALL go IDLE->FLUSH on the first clk cycle with sync_reset low.
REQ-016 SHALL hold dl_sync_reset=1 in FLUSH for exactly FLUSH_LEN cycles, counted by a 4-bit flush counter, then go to RUN.
REQ-017 SHALL, on stimer_wr in RUN, enter FLUSH on the next cycle and clear both prescalers to 0.
REQ-018 SHALL, on stimer_wr in FLUSH, restart the flush counter so that FLUSH lasts FLUSH_LEN cycles from that request.
REQ-019 SHALL run two 7-bit prescalers (cnt64, cnt15) only in RUN; each advances on clk_en_in and wraps to 0 after DIV-1; both are held at 0 in IDLE and FLUSH.
REQ-020 SHALL register every strobe; output latency is 1 clk after the clk_en_in that causes it.
REQ-021 SHALL assert base_strobe for 1 cycle after the clk_en_in on which the selected prescaler equals DIV-1.
REQ-022 SHALL set ch_enable[i] to the registered clk_en_in if ch_fast[i]=1, and otherwise to base_strobe's next value.
REQ-023 SHALL force ch_enable and base_strobe to 0 outside RUN, including in the cycle stimer_wr is sampled.
REQ-024 SHALL apply a base_15k change at the next prescaler wrap, without resetting the prescalers.
REQ-025 SHALL keep the first base_strobe after a flush exactly DIV clk_en_in ticks after entering RUN.

Reset
REQ-026 SHALL, while sync_reset=1, put the state in IDLE, clear the counters, and drive ch_enable=0, base_strobe=0, dl_sync_reset=0 and busy=1.
REQ-027 SHALL give sync_reset priority over stimer_wr and clk_en_in in the same cycle.
REQ-028 SHALL, on reset during FLUSH or RUN, abort immediately and re-flush once reset is released.

Configuration
REQ-029 SHALL, with macro POKEY_SCHED_DONE_EN defined, add output flush_done (1 bit), a one-cycle pulse in the first RUN cycle after each FLUSH, reset value 0.
REQ-030 SHALL, without POKEY_SCHED_DONE_EN, have neither the port nor its logic; all other behaviour is identical.

Structure
REQ-031 SHALL put the FSM state enum and the default DIV64/DIV15/FLUSH_LEN constants in the shared pokey package.
REQ-032 SHALL use one sub-module, pokey_prescaler (counter, wrap compare, registered strobe), instantiated twice.

Verification
REQ-033 SHALL verify: reset released, clk_en_in every 4 clk -> dl_sync_reset high cycles 2..5 (FLUSH_LEN=4), busy falls with RUN, all enables 0 until then.
REQ-034 SHALL verify: RUN, base_15k=0, ch_fast=0000, continuous ticks -> ch_enable=1111 for 1 cycle every 28 ticks; the first strobe comes on tick 28 after RUN.
REQ-035 SHALL verify: ch_fast=0101, base_15k=1 -> ch_enable[0],[2] pulse every tick; ch_enable[1],[3] pulse every 114 ticks.
REQ-036 SHALL verify: stimer_wr mid-count (cnt64=17) -> enables 0 next cycle, 4-cycle flush, the next strobe 28 ticks after RUN re-entry.
REQ-037 SHALL verify: stimer_wr on flush cycle 3 -> flush extends to 4 cycles from the request; sync_reset together with stimer_wr -> IDLE, dl_sync_reset=0.
REQ-038 SHALL verify, with POKEY_SCHED_DONE_EN: exactly one flush_done pulse per flush, coincident with busy falling.
